alu_arbiter: RTL
================

# alu_arbiter

Sequencer that shares one registered `ALU` instance between two independent requesters. Each requester presents operands and an operation code through a valid/ready handshake. The block arbitrates round-robin, drives the ALU from held operand registers, and waits the ALU's fixed latency. It then returns result, flags and requester ID on a single response channel with backpressure. It sits between the requesting engines and the ALU and is the only driver of the ALU's `i_arg0`, `i_arg1` and `i_oper`.

## Interface
- `WIDTH`, 8: operand/result width; must equal the connected ALU's `WIDTH`.
- `LATENCY`, 1: cycles from operands first driven on `o_alu_*` to a valid `i_alu_result`/`i_alu_flag`; legal range 1..15.

Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- `i_CLK`  in  1  clock; all state changes on its rising edge.
- `i_RSTn`  in  1  asynchronous, active-low reset.

Requester 0:
- `i_req0_valid`  in  1  request pending.
- `o_req0_ready`  out  1  request accepted this cycle.
- `i_req0_arg0`, `i_req0_arg1`  in  WIDTH each  operands, signed.
- `i_req0_oper`  in  2  ALU operation code.

Requester 1:
- `i_req1_valid`, `o_req1_ready`, `i_req1_arg0`, `i_req1_arg1`, `i_req1_oper`: same as requester 0.

ALU side:
- `o_alu_arg0`, `o_alu_arg1`  out  WIDTH each  to ALU `i_arg0`/`i_arg1`.
- `o_alu_oper`  out  2  to ALU `i_oper`.
- `i_alu_result`  in  WIDTH  from ALU `o_result`.
- `i_alu_flag`  in  3  from ALU `o_flag`.

Response:
- `o_rsp_valid`  out  1  response available.
- `i_rsp_ready`  in  1  consumer accepts the response.
- `o_rsp_id`  out  1  requester that issued the operation.
- `o_rsp_result`  out  WIDTH  captured ALU result.
- `o_rsp_flag`  out  3  captured ALU flags.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - Grant goes to the single valid requester. If both are valid, grant goes to the requester not granted last.
  - `o_reqN_ready = (state==IDLE) && grant==N`. This is combinational from the valids and the pointer; at most one ready is high.
  - A request handshake is valid && ready at a rising edge. On a handshake:
    - capture arg0/arg1/oper into the operand registers and the ID into the tag register;
    - update last-grant pointer to N;
    - load wait counter with LATENCY;
    - go to WAIT.
- **WAIT:**
  - Each edge: if counter==0, capture `i_alu_result`/`i_alu_flag` into the response registers and go to RESP; otherwise decrement the counter.
  - Requester readies are low.
- **RESP:**
  - `o_rsp_valid=1`; result, flag and ID are stable until accepted.
  - On an edge with `i_rsp_ready=1`, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- **Operand registers:**
  - `o_alu_*` are driven from these registers only.
  - They hold their value outside WAIT; they are not cleared.
- **Result path:** no arithmetic in this block; result and flags are passed through bit-exact.
- **Requester contract:** a requester may drop valid or change payload while not granted. No effect until a handshake.

## Timing
- Reset values:
  - state IDLE; last-grant pointer = 1, so requester 0 wins the first tie;
  - counter 0;
  - all `o_alu_*`, `o_rsp_result`, `o_rsp_flag` and `o_rsp_id` = 0;
  - `o_rsp_valid` = 0; both readies 0 while reset is asserted.
- Request handshake at edge E0: operands appear on `o_alu_*` right after E0. The ALU samples them at E1. The result is captured at edge E0+LATENCY+1. `o_rsp_valid` rises after that edge.
- Request-to-response latency is LATENCY+1 cycles.
- Minimum issue interval is LATENCY+3 cycles when the consumer is always ready.
- Reset asserted mid-operation (WAIT or RESP):
  - immediate return to reset values;
  - the in-flight operation is dropped and no response is produced;
  - the pointer is reset.
- `i_rsp_ready` held low: the block stays in RESP indefinitely. Both readies stay low.
- Simultaneous valids on consecutive operations alternate grants 0,1,0,1.

## Test plan
- **Single request, consumer always ready.** Use a registered stub ALU (result = arg0+arg1, flag 3'b101) and LATENCY=1. Drive req0 with arg0=8'd5, arg1=8'd3, oper 2'b00.
  - Response: `o_rsp_valid` high 2 cycles after the handshake, result 8'd8, flag 3'b101, id 0.
- **Both valid every cycle, consumer always ready.** req0 = (1,1), req1 = (2,2).
  - Responses alternate: id 0 with result 2, id 1 with result 4, id 0, and so on.
  - The first grant goes to 0; the issue interval is 4 cycles.
- **Response backpressure.** `i_rsp_ready` low for 10 cycles during RESP.
  - `o_rsp_*` stay stable and both readies stay 0.
  - Raising ready gives one handshake, then IDLE.
- **Reset in WAIT.** Pulse `i_RSTn` low one cycle after a request handshake.
  - No response; all outputs return to 0.
  - The next tie grants requester 0.
- **LATENCY=3 with the stub delayed 3 cycles.**
  - The result is captured exactly 4 cycles after the handshake.
  - A stub that presents the wrong value on cycles 1-3 is never latched.
- **Real `ALU`, WIDTH=8.** Random signed operands with all four oper codes, 20 operations each, alternating requesters.
  - Each `o_rsp_result`/`o_rsp_flag` equals the ALU output for the captured operands.
  - `o_rsp_id` matches the issuing requester.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters.
// Round-robin grant between requester 0 and 1, operands held in registers that
// drive the ALU, fixed-latency wait, then result/flags/id presented on a
// response channel with backpressure.
//
// Ports
//   i_CLK, i_RSTn                     clock, async active-low reset
//   i_reqN_valid / o_reqN_ready       request handshake, N = 0,1
//   i_reqN_arg0, i_reqN_arg1          operands (WIDTH, signed)
//   i_reqN_oper                       ALU operation code (2)
//   o_alu_arg0, o_alu_arg1, o_alu_oper  held operands to the ALU
//   i_alu_result, i_alu_flag          ALU outputs
//   o_rsp_valid / i_rsp_ready         response handshake
//   o_rsp_id, o_rsp_result, o_rsp_flag  captured response
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | arbitrating; one requester ready when any is valid
// ST_WAIT | operands on the ALU, counting down the ALU latency
// ST_RESP | response valid, held until the consumer accepts it

module alu_arbiter #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1
) (
   input  logic             i_CLK,
   input  logic             i_RSTn,

   input  logic             i_req0_valid,
   output logic             o_req0_ready,
   input  logic [WIDTH-1:0] i_req0_arg0,
   input  logic [WIDTH-1:0] i_req0_arg1,
   input  logic [1:0]       i_req0_oper,

   input  logic             i_req1_valid,
   output logic             o_req1_ready,
   input  logic [WIDTH-1:0] i_req1_arg0,
   input  logic [WIDTH-1:0] i_req1_arg1,
   input  logic [1:0]       i_req1_oper,

   output logic [WIDTH-1:0] o_alu_arg0,
   output logic [WIDTH-1:0] o_alu_arg1,
   output logic [1:0]       o_alu_oper,
   input  logic [WIDTH-1:0] i_alu_result,
   input  logic [2:0]       i_alu_flag,

   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic             o_rsp_id,
   output logic [WIDTH-1:0] o_rsp_result,
   output logic [2:0]       o_rsp_flag
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY);

   state_t     state;
   state_t     state_nxt;
   logic       last_grant;
   logic       grant_any;
   logic       grant_id;
   logic       req_hs;
   logic       tag_id;
   logic [3:0] wait_cnt;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant_any = i_req0_valid | i_req1_valid;
      if (i_req0_valid && i_req1_valid) begin
         grant_id = ~last_grant;
      end else begin
         grant_id = i_req1_valid;
      end
   end

   // Readies are gated by reset so nothing looks accepted while held in reset.
   assign o_req0_ready = i_RSTn && (state == ST_IDLE) && grant_any && !grant_id;
   assign o_req1_ready = i_RSTn && (state == ST_IDLE) && grant_any &&  grant_id;
   assign req_hs       = o_req0_ready | o_req1_ready;
   assign o_rsp_valid  = (state == ST_RESP);

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_hs)            state_nxt = ST_WAIT;
         ST_WAIT: if (wait_cnt == 4'd0)  state_nxt = ST_RESP;
         ST_RESP: if (i_rsp_ready)       state_nxt = ST_IDLE;
         default:                        state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         last_grant   <= 1'b1;
         wait_cnt     <= 4'd0;
         tag_id       <= 1'b0;
         o_alu_arg0   <= '0;
         o_alu_arg1   <= '0;
         o_alu_oper   <= 2'b00;
         o_rsp_id     <= 1'b0;
         o_rsp_result <= '0;
         o_rsp_flag   <= 3'b000;
      end else begin
         if ((state == ST_IDLE) && req_hs) begin
            if (grant_id) begin
               o_alu_arg0 <= i_req1_arg0;
               o_alu_arg1 <= i_req1_arg1;
               o_alu_oper <= i_req1_oper;
            end else begin
               o_alu_arg0 <= i_req0_arg0;
               o_alu_arg1 <= i_req0_arg1;
               o_alu_oper <= i_req0_oper;
            end
            tag_id     <= grant_id;
            last_grant <= grant_id;
            wait_cnt   <= CNT_LOAD;
         end else if (state == ST_WAIT) begin
            // Counter starts at LATENCY, so capture lands LATENCY+1 edges after accept.
            if (wait_cnt == 4'd0) begin
               o_rsp_result <= i_alu_result;
               o_rsp_flag   <= i_alu_flag;
               o_rsp_id     <= tag_id;
            end else begin
               wait_cnt <= wait_cnt - 4'd1;
            end
         end
      end
   end

endmodule
